// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial carry-look-ahead adder controller.
// Contents: FSM state enum, nibble slice width, counter-width helper.
package serial_add_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// 4-bit generate/propagate carry-look-ahead adder slice.
// Ports: a, b  - 4-bit operand nibbles
//        cin   - carry into the slice
//        s     - 4-bit nibble sum
//        cout  - carry out of the slice
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    g = a & b;
    p = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
    s = p ^ c;
  end

endmodule

// File: rtl/serial_cla_add_ctrl.sv
// Serial adder: {cout,sum} = a + b + cin computed one nibble per cycle
// through a single 4-bit CLA slice, least-significant nibble first.
// Latency from the accept cycle to out_valid is WIDTH/4 + 1 cycles.
// Ports: clk, rst_n (async, active-low)
//        in_valid/in_ready, a, b, cin     - operation request
//        sub (only with SERIAL_ADD_SUB_EN) - 1: compute a - b (cin ignored)
//        out_valid/out_ready, sum, cout   - result handshake
//        busy                             - high while RUN or DONE
// Optional feature macro: SERIAL_ADD_SUB_EN
module serial_cla_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned N  = WIDTH / SLICE_W;
  localparam int unsigned CW = (clog2(N) < 1) ? 1 : clog2(N);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic             carry_r, cout_r;
  logic [CW-1:0]    k;
  logic             last;
  logic [3:0]       sl_a, sl_b, sl_s;
  logic             sl_co;

  always_comb begin
    sl_a = a_r[k*SLICE_W +: SLICE_W];
    sl_b = b_r[k*SLICE_W +: SLICE_W];
    last = (k == CW'(N - 1));
  end

  cla4_slice u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_r),
    .s    (sl_s),
    .cout (sl_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is folded in at capture time (b inverted, carry seeded
  // with 1), so the RUN datapath is identical for add and subtract.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      k       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= a;
            k   <= '0;
`ifdef SERIAL_ADD_SUB_EN
            if (sub) begin
              b_r     <= ~b;
              carry_r <= 1'b1;
            end else begin
              b_r     <= b;
              carry_r <= cin;
            end
`else
            b_r     <= b;
            carry_r <= cin;
`endif
          end
        end
        RUN: begin
          sum_r[k*SLICE_W +: SLICE_W] <= sl_s;
          carry_r                     <= sl_co;
          k                           <= k + 1'b1;
          if (last) cout_r <= sl_co;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sum  = sum_r;
    cout = cout_r;
  end

endmodule

// File: tb/tb_serial_cla_add_ctrl.sv
// Self-checking bench for serial_cla_add_ctrl (WIDTH=16).
// Reference results come from plain arithmetic on the operands; also
// exercises the SERIAL_ADD_SUB_EN build when that macro is defined.
module tb_serial_cla_add_ctrl;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned N     = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b, sum;
  logic             cin;
  logic             sub_drv;
  logic             out_valid;
  logic             out_ready;
  logic             cout;
  logic             busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_cla_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub_drv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  function automatic logic [WIDTH:0] ref_op(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y,
                                            input logic c, input logic s);
    if (s) return {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
    return {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issues one operation from IDLE and waits (bounded) for out_valid,
  // leaving the result pending with out_ready low.
  task automatic do_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                       input logic xc, input logic xs,
                       output logic [WIDTH-1:0] s, output logic co,
                       output int lat);
    a = xa; b = xb; cin = xc; sub_drv = xs;
    in_valid = 1'b1; out_ready = 1'b0;
    step;
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 50) begin
      step;
      lat++;
    end
    s = sum; co = cout;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub_drv = 1'b0;
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        sum !== '0 || cout !== 1'b0)
      begin errors++; $display("FAIL reset_state: rdy=%b vld=%b busy=%b sum=%h cout=%b required 1 0 0 0000 0",
                               in_ready, out_valid, busy, sum, cout); end
    step; step;
    rst_n = 1'b1;
    // first edge after release must accept
    in_valid = 1'b1; a = 16'h0003; b = 16'h0004; cin = 1'b0;
    step;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0)
      begin errors++; $display("FAIL first_accept: busy=%b in_ready=%b required 1 0", busy, in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 20 && busy; i++) step;
    out_ready = 1'b0;
    checks++;
    if (sum !== 16'h0007 || cout !== 1'b0)
      begin errors++; $display("FAIL first_result: sum=%h cout=%b required 0007 0", sum, cout); end
  endtask

  task automatic test_latency;
    logic [WIDTH-1:0] s;
    logic co;
    int lat;
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, co, lat);
    checks++;
    if (lat !== N + 1)
      begin errors++; $display("FAIL latency: got %0d required %0d", lat, N + 1); end
    checks++;
    if (s !== 16'h0000 || co !== 1'b1)
      begin errors++; $display("FAIL ffff_plus_1: sum=%h cout=%b required 0000 1", s, co); end
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0)
      begin errors++; $display("FAIL done_flags: busy=%b in_ready=%b required 1 0", busy, in_ready); end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0000 || cout !== 1'b1)
      begin errors++; $display("FAIL idle_hold: vld=%b rdy=%b sum=%h cout=%b required 0 1 0000 1",
                               out_valid, in_ready, sum, cout); end
  endtask

  task automatic test_backpressure;
    logic [WIDTH-1:0] s;
    logic co;
    int lat;
    do_op(16'h1234, 16'h4321, 1'b1, 1'b0, s, co, lat);
    checks++;
    if (s !== 16'h5556 || co !== 1'b0)
      begin errors++; $display("FAIL add_1234_4321: sum=%h cout=%b required 5556 0", s, co); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      step;
      checks++;
      if (out_valid !== 1'b1 || sum !== 16'h5556 || cout !== 1'b0 || in_ready !== 1'b0)
        begin errors++; $display("FAIL stall_hold[%0d]: vld=%b sum=%h cout=%b rdy=%b required 1 5556 0 0",
                                 i, out_valid, sum, cout, in_ready); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0)
      begin errors++; $display("FAIL stall_release: vld=%b required 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [WIDTH:0] q[$];
    logic [WIDTH:0] exp;
    int last_acc;
    bit have_acc;
    int results;
    have_acc = 0; results = 0; last_acc = 0;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      sub_drv = 1'($urandom);
`else
      sub_drv = 1'b0;
`endif
      out_ready = 1'($urandom_range(0, 1));
      checks++;
      if (busy && in_ready !== 1'b0)
        begin errors++; $display("FAIL ready_while_busy: cyc=%0d in_ready=%b required 0", cyc, in_ready); end
      if (in_valid && in_ready) begin
        if (have_acc) begin
          checks++;
          if (cyc - last_acc < int'(N + 2))
            begin errors++; $display("FAIL accept_spacing: got %0d required >=%0d", cyc - last_acc, N + 2); end
        end
        q.push_back(ref_op(a, b, cin, sub_drv));
        last_acc = cyc; have_acc = 1;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL spurious_result: sum=%h required no result", sum);
        end else begin
          exp = q.pop_front();
          results++;
          if ({cout, sum} !== exp)
            begin errors++; $display("FAIL random_result: got %h required %h", {cout, sum}, exp); end
        end
      end
      step;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      out_ready = 1'b1;
      if (out_valid) begin
        exp = q.pop_front();
        checks++;
        if ({cout, sum} !== exp)
          begin errors++; $display("FAIL drain_result: got %h required %h", {cout, sum}, exp); end
      end
      step;
    end
    out_ready = 1'b0;
    checks++;
    if (q.size() != 0 || results < 10)
      begin errors++; $display("FAIL random_count: pending=%0d results=%0d required 0 >=10", q.size(), results); end
  endtask

  task automatic test_reset_mid_run;
    logic [WIDTH-1:0] s;
    logic co;
    int lat;
    bit seen;
    in_valid = 1'b1; a = 16'h1357; b = 16'h2468; cin = 1'b1;
    step;
    in_valid = 1'b0;
    step;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        sum !== '0 || cout !== 1'b0)
      begin errors++; $display("FAIL reset_abort: rdy=%b vld=%b busy=%b sum=%h cout=%b required 1 0 0 0000 0",
                               in_ready, out_valid, busy, sum, cout); end
    step;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      out_ready = 1'b1;
      step;
      if (out_valid) seen = 1;
    end
    out_ready = 1'b0;
    checks++;
    if (seen)
      begin errors++; $display("FAIL no_result_after_abort: out_valid seen=1 required 0"); end
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, s, co, lat);
    checks++;
    if (s !== 16'h0100 || co !== 1'b0 || lat !== N + 1)
      begin errors++; $display("FAIL post_reset_op: sum=%h cout=%b lat=%0d required 0100 0 %0d", s, co, lat, N + 1); end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub;
    logic [WIDTH-1:0] s;
    logic co;
    int lat;
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, s, co, lat);
    checks++;
    if (s !== 16'hFFFE || co !== 1'b0)
      begin errors++; $display("FAIL sub_5_7: sum=%h cout=%b required fffe 0", s, co); end
    out_ready = 1'b1; step; out_ready = 1'b0;
    do_op(16'h0007, 16'h0005, 1'b0, 1'b1, s, co, lat);
    checks++;
    if (s !== 16'h0002 || co !== 1'b1)
      begin errors++; $display("FAIL sub_7_5: sum=%h cout=%b required 0002 1", s, co); end
    out_ready = 1'b1; step; out_ready = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_latency;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_run;
`ifdef SERIAL_ADD_SUB_EN
    test_sub;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
